// File: rtl/cn_clk_gen_pkg.sv
// cn_clk_gen_pkg: shared types for the divided-clock generator.
//   ch_state_e - per-channel sequencing state
//   ch_cfg_t   - one channel's configuration (ratio, skew, enable)
//   eff_div()  - clamps a requested ratio to the smallest legal period of 2
// The field widths here set the per-channel datapath width used by cn_clk_gen_ch.
package cn_clk_gen_pkg;

    localparam int unsigned CN_DIV_W  = 8;
    localparam int unsigned CN_SKEW_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } ch_state_e;

    typedef struct packed {
        logic [CN_DIV_W-1:0]  div;
        logic [CN_SKEW_W-1:0] skew;
        logic                 en;
    } ch_cfg_t;

    // Ratios 0 and 1 cannot form a clock; both fall back to a period of 2.
    function automatic logic [CN_DIV_W-1:0] eff_div(input logic [CN_DIV_W-1:0] div);
        return (div < CN_DIV_W'(2)) ? CN_DIV_W'(2) : div;
    endfunction

endpackage

// File: rtl/cn_clk_gen_ch.sv
// cn_clk_gen_ch: one channel of the divided-clock generator.
// Counter, three-state sequencer, pending-config register, skew delay line
// and (optionally) a glitch-free output gate.
// Optional macro: CN_CLK_GEN_GATE_EN adds gate_en and gates clk_out.
// Ports:
//   clk, rst          sole clock, synchronous active-high reset
//   cfg_vld/cfg_rdy   configuration handshake
//   cfg_div/skew/en   requested ratio, skew and run enable
//   gate_en           (macro only) output gate request
//   clk_ideal         registered divided clock
//   clk_out           clk_ideal delayed by the active skew (gated if enabled)
//   tick              one-cycle pulse on each clk_ideal rising edge
//
// state | meaning
// IDLE  | stopped; clk_ideal low, accepts config (en=1 starts a period next cycle)
// RUN   | counting; accepts config into the pending register
// PEND  | counting with old config; new config applied at the period end
module cn_clk_gen_ch
    import cn_clk_gen_pkg::*;
#(
    parameter int unsigned MAX_SKEW = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_vld,
    output logic                 cfg_rdy,
    input  logic [CN_DIV_W-1:0]  cfg_div,
    input  logic [CN_SKEW_W-1:0] cfg_skew,
    input  logic                 cfg_en,
`ifdef CN_CLK_GEN_GATE_EN
    input  logic                 gate_en,
`endif
    output logic                 clk_ideal,
    output logic                 clk_out,
    output logic                 tick
);

    ch_state_e            state_q, state_d;
    logic [CN_DIV_W-1:0]  cnt_q, cnt_d;
    logic [CN_DIV_W-1:0]  div_q, div_d;
    logic [CN_SKEW_W-1:0] skew_q, skew_d;
    ch_cfg_t              pend_q, pend_d;
    logic                 clk_ideal_q, clk_ideal_d;
    logic                 tick_q, tick_d;
    logic [MAX_SKEW-1:0]  line_q, line_d;

    ch_cfg_t              cfg_in;
    logic                 hs;
    logic                 last;
    logic [CN_DIV_W-1:0]  cnt_inc;
    logic                 run_d;
    logic [MAX_SKEW:0]    taps;
    logic                 dly_clk;

    assign cfg_rdy = (state_q != PEND);

    // Tap 0 is clk_ideal itself; tap k is clk_ideal k cycles ago.
    assign taps    = {line_q, clk_ideal_q};
    assign dly_clk = taps[skew_q];

    always_comb begin
        cfg_in.div  = eff_div(cfg_div);
        cfg_in.skew = (32'(cfg_skew) > MAX_SKEW) ? CN_SKEW_W'(MAX_SKEW) : cfg_skew;
        cfg_in.en   = cfg_en;
        hs          = cfg_vld & cfg_rdy;
        last        = (cnt_q == div_q - CN_DIV_W'(1));
        cnt_inc     = last ? '0 : cnt_q + CN_DIV_W'(1);

        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        skew_d  = skew_q;
        pend_d  = pend_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (hs) begin
                    div_d  = cfg_in.div;
                    skew_d = cfg_in.skew;
                    if (cfg_in.en) state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (hs) begin
                    pend_d  = cfg_in;
                    state_d = PEND;
                end
            end
            PEND: begin
                cnt_d = cnt_inc;
                // Swap config only as the current period closes: no runt pulse.
                if (last) begin
                    div_d   = pend_q.div;
                    skew_d  = pend_q.skew;
                    state_d = pend_q.en ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next count so they line up with it.
        run_d       = (state_d != IDLE);
        clk_ideal_d = run_d && (cnt_d < (div_d >> 1));
        tick_d      = run_d && (cnt_d == '0);
        line_d      = taps[MAX_SKEW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= CN_DIV_W'(2);
            skew_q      <= '0;
            pend_q      <= '0;
            clk_ideal_q <= 1'b0;
            tick_q      <= 1'b0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            skew_q      <= skew_d;
            pend_q      <= pend_d;
            clk_ideal_q <= clk_ideal_d;
            tick_q      <= tick_d;
            line_q      <= line_d;
        end
    end

    assign clk_ideal = clk_ideal_q;
    assign tick      = tick_q;

`ifdef CN_CLK_GEN_GATE_EN
    logic gate_q, gate_d;

    // The gate only follows gate_en while the delayed clock is low, so a high
    // phase is either passed whole or suppressed whole.
    always_comb begin
        gate_d = dly_clk ? gate_q : gate_en;
    end

    always_ff @(posedge clk) begin
        if (rst) gate_q <= 1'b0;
        else     gate_q <= gate_d;
    end

    assign clk_out = dly_clk & gate_q;
`else
    assign clk_out = dly_clk;
`endif

endmodule

// File: rtl/cn_clk_gen.sv
// cn_clk_gen: multi-channel divided-clock generator.
// NUM_CH independent channels, each with its own handshake, ratio and skew.
// Optional macro: CN_CLK_GEN_GATE_EN adds per-channel gate_en for clk_out.
// Ports:
//   clk, rst      sole clock, synchronous active-high reset
//   cfg_vld/rdy   per-channel config handshake
//   cfg_div       channel c at [c*DIV_W +: DIV_W]
//   cfg_skew      channel c at [c*SKEW_W +: SKEW_W]
//   cfg_en        per-channel run enable
//   gate_en       (macro only) per-channel clk_out gate
//   clk_ideal     divided clocks; clk_out skewed copies; tick period pulses
// DIV_W/SKEW_W must match the package field widths.
module cn_clk_gen
    import cn_clk_gen_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DIV_W    = CN_DIV_W,
    parameter int unsigned MAX_SKEW = 7,
    parameter int unsigned SKEW_W   = CN_SKEW_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        cfg_vld,
    output logic [NUM_CH-1:0]        cfg_rdy,
    input  logic [NUM_CH*DIV_W-1:0]  cfg_div,
    input  logic [NUM_CH*SKEW_W-1:0] cfg_skew,
    input  logic [NUM_CH-1:0]        cfg_en,
`ifdef CN_CLK_GEN_GATE_EN
    input  logic [NUM_CH-1:0]        gate_en,
`endif
    output logic [NUM_CH-1:0]        clk_ideal,
    output logic [NUM_CH-1:0]        clk_out,
    output logic [NUM_CH-1:0]        tick
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cn_clk_gen_ch #(
            .MAX_SKEW (MAX_SKEW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .cfg_vld   (cfg_vld[c]),
            .cfg_rdy   (cfg_rdy[c]),
            .cfg_div   (cfg_div[c*DIV_W +: DIV_W]),
            .cfg_skew  (cfg_skew[c*SKEW_W +: SKEW_W]),
            .cfg_en    (cfg_en[c]),
`ifdef CN_CLK_GEN_GATE_EN
            .gate_en   (gate_en[c]),
`endif
            .clk_ideal (clk_ideal[c]),
            .clk_out   (clk_out[c]),
            .tick      (tick[c])
        );
    end

endmodule

// File: tb/tb_cn_clk_gen.sv
// Bench for cn_clk_gen: a cycle-level reference model (period start times,
// ratio arithmetic and a history of the ideal clock) pushes the expected
// outputs of every edge into a queue; an independent monitor pops and compares.
module tb_cn_clk_gen;

    localparam int NUM_CH   = 4;
    localparam int DIV_W    = 8;
    localparam int MAX_SKEW = 7;
    localparam int SKEW_W   = 3;
    localparam int HMAX     = 8192;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_CH-1:0]        cfg_vld = '0;
    logic [NUM_CH-1:0]        cfg_rdy;
    logic [NUM_CH*DIV_W-1:0]  cfg_div = '0;
    logic [NUM_CH*SKEW_W-1:0] cfg_skew = '0;
    logic [NUM_CH-1:0]        cfg_en = '0;
    logic [NUM_CH-1:0]        clk_ideal, clk_out, tick;
`ifdef CN_CLK_GEN_GATE_EN
    logic [NUM_CH-1:0]        gate_en = '1;
    bit                       gate_req[NUM_CH];
    bit                       m_gate[NUM_CH];
    bit                       m_dly[NUM_CH];
`endif

    cn_clk_gen #(
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .MAX_SKEW (MAX_SKEW),
        .SKEW_W   (SKEW_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_vld   (cfg_vld),
        .cfg_rdy   (cfg_rdy),
        .cfg_div   (cfg_div),
        .cfg_skew  (cfg_skew),
        .cfg_en    (cfg_en),
`ifdef CN_CLK_GEN_GATE_EN
        .gate_en   (gate_en),
`endif
        .clk_ideal (clk_ideal),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH-1:0] ideal;
        logic [NUM_CH-1:0] out;
        logic [NUM_CH-1:0] tck;
        logic [NUM_CH-1:0] rdy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Requester: holds a request until the model says it was accepted.
    bit req[NUM_CH];
    int req_div[NUM_CH];
    int req_skew[NUM_CH];
    bit req_en[NUM_CH];
    bit rst_req = 1'b1;

    // Reference model state.
    int t_now = 0;
    bit m_run[NUM_CH];
    bit m_has_pend[NUM_CH];
    int m_n[NUM_CH];
    int m_s[NUM_CH];
    int m_t0[NUM_CH];
    int m_pn[NUM_CH];
    int m_ps[NUM_CH];
    bit m_pen[NUM_CH];
    bit hist[NUM_CH][HMAX];

    function automatic int eff_n(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int eff_s(input int s);
        return (s > MAX_SKEW) ? MAX_SKEW : s;
    endfunction

    function automatic void chk(input string name, input logic [NUM_CH-1:0] act,
                                input logic [NUM_CH-1:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp_v);
        end
    endfunction

    // One clock cycle: drive inputs for the next edge, advance the model over
    // that edge and queue what the outputs must be after it.
    task automatic cyc();
        exp_t e;
        bit   hs;
        bit   dly;
        int   idx;
        @(negedge clk);
        rst = rst_req;
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_vld[c] = req[c];
            cfg_div[c*DIV_W +: DIV_W] = DIV_W'(req_div[c]);
            cfg_skew[c*SKEW_W +: SKEW_W] = SKEW_W'(req_skew[c]);
            cfg_en[c] = req_en[c];
`ifdef CN_CLK_GEN_GATE_EN
            gate_en[c] = gate_req[c];
`endif
        end
        t_now++;
        e = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst_req) begin
                m_run[c] = 1'b0;
                m_has_pend[c] = 1'b0;
                m_n[c] = 2;
                m_s[c] = 0;
                for (int k = 1; k <= MAX_SKEW; k++)
                    if (t_now - k >= 0) hist[c][t_now-k] = 1'b0;
            end else begin
                hs = req[c] && !m_has_pend[c];
                if (m_run[c]) begin
                    if (t_now - m_t0[c] == m_n[c]) begin
                        if (m_has_pend[c]) begin
                            m_n[c] = m_pn[c];
                            m_s[c] = m_ps[c];
                            m_run[c] = m_pen[c];
                            m_has_pend[c] = 1'b0;
                        end
                        m_t0[c] = t_now;
                    end
                    if (hs) begin
                        m_pn[c] = eff_n(req_div[c]);
                        m_ps[c] = eff_s(req_skew[c]);
                        m_pen[c] = req_en[c];
                        m_has_pend[c] = 1'b1;
                    end
                end else if (hs) begin
                    m_n[c] = eff_n(req_div[c]);
                    m_s[c] = eff_s(req_skew[c]);
                    if (req_en[c]) begin
                        m_run[c] = 1'b1;
                        m_t0[c] = t_now;
                    end
                end
                if (hs) req[c] = 1'b0;
            end
            hist[c][t_now] = m_run[c] && ((t_now - m_t0[c]) < m_n[c] / 2);
            idx = t_now - m_s[c];
            dly = (idx >= 0) ? hist[c][idx] : 1'b0;
            e.ideal[c] = hist[c][t_now];
            e.tck[c]   = m_run[c] && (t_now == m_t0[c]);
            e.rdy[c]   = !m_has_pend[c];
`ifdef CN_CLK_GEN_GATE_EN
            if (rst_req) m_gate[c] = 1'b0;
            else if (!m_dly[c]) m_gate[c] = gate_req[c];
            m_dly[c] = rst_req ? 1'b0 : dly;
            e.out[c] = dly & m_gate[c];
`else
            e.out[c] = dly;
`endif
        end
        sb_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic request(input int c, input int d, input int s, input bit en);
        req[c] = 1'b1;
        req_div[c] = d;
        req_skew[c] = s;
        req_en[c] = en;
    endtask

    // Advance until channel c is running at period position pos (bounded).
    task automatic wait_pos(input int c, input int pos, input string name);
        int budget;
        budget = 0;
        while (!(m_run[c] && (t_now - m_t0[c]) == pos) && budget < 300) begin
            cyc();
            budget++;
        end
        n_checks++;
        if (budget >= 300) begin
            n_fail++;
            $display("FAIL %s: position %0d never reached, waited %0d cycles", name, pos, budget);
        end
    endtask

    // Monitor: checks every edge's outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("clk_ideal", clk_ideal, e.ideal);
                chk("clk_out", clk_out, e.out);
                chk("tick", tick, e.tck);
                chk("cfg_rdy", cfg_rdy, e.rdy);
            end
        end
    end

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            m_n[c] = 2;
`ifdef CN_CLK_GEN_GATE_EN
            gate_req[c] = 1'b1;
`endif
        end
        rst_req = 1'b1;
        run(3);
        rst_req = 1'b0;
        run(2);

        // ch0 div 4, no skew
        request(0, 4, 0, 1'b1);
        run(14);

        // ch1 div 5 skew 3, then the degenerate ratios 0 and 1
        request(1, 5, 3, 1'b1);
        run(25);
        request(1, 0, 3, 1'b1);
        run(12);
        request(1, 1, 1, 1'b1);
        run(12);

        // ch0 reconfigured mid-period to div 6
        wait_pos(0, 1, "ch0_midperiod");
        request(0, 6, 0, 1'b1);
        run(20);

        // ch2 start, stop with drain, restart
        request(2, 3, 5, 1'b1);
        run(12);
        request(2, 4, 5, 1'b0);
        run(20);
        request(2, 4, 2, 1'b1);
        run(14);

        // simultaneous handshakes on all channels, then reset at ch3 cnt 2
        request(3, 6, 4, 1'b1);
        run(12);
        for (int c = 0; c < NUM_CH; c++) request(c, 7 + c, 6 - c, 1'b1);
        cyc();
        wait_pos(3, 2, "ch3_cnt2");
        rst_req = 1'b1;
        cyc();
        rst_req = 1'b0;
        run(10);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!req[c] && $urandom_range(0, 19) == 0)
                    request(c, $urandom_range(0, 12), $urandom_range(0, MAX_SKEW),
                            $urandom_range(0, 3) != 0);
`ifdef CN_CLK_GEN_GATE_EN
                if ($urandom_range(0, 9) == 0) gate_req[c] = !gate_req[c];
`endif
            end
            rst_req = ($urandom_range(0, 399) == 0);
            cyc();
        end
        rst_req = 1'b0;
        run(2);

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cn_clk_gen.md
Name: cn_clk_gen

Overview:
- Multi-channel divided-clock generator for bench clock domains.
- Each channel produces:
  - an ideal divided clock;
  - a "wire" clock, which is the ideal clock delayed by a programmable number of cycles;
  - a per-period tick.
- Ratio, skew and enable are reprogrammable at runtime through a per-channel valid/ready handshake.
- Updates take effect only at period boundaries, so no runt pulses are produced.

Parameters:
- NUM_CH, 4, number of independent channels
- DIV_W, 8, width of the divide-ratio field
- MAX_SKEW, 7, maximum programmable skew in clk cycles
- SKEW_W, 3, width of the skew field (>= clog2(MAX_SKEW+1))

Ports:
- clk  in  1  sole clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- cfg_vld  in  NUM_CH  per-channel config valid
- cfg_rdy  out  NUM_CH  per-channel config ready
- cfg_div  in  NUM_CH*DIV_W  requested divide ratio, channel c at [c*DIV_W +: DIV_W]
- cfg_skew  in  NUM_CH*SKEW_W  requested skew in cycles
- cfg_en  in  NUM_CH  1 = run, 0 = stop
- clk_ideal  out  NUM_CH  registered divided clock
- clk_out  out  NUM_CH  clk_ideal delayed by the active skew
- tick  out  NUM_CH  1-cycle pulse on each clk_ideal rising edge

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - cfg_rdy = all 1.
  - clk_ideal, clk_out, tick = 0.
  - Every channel in IDLE, cnt = 0, skew line cleared.
- Effective ratio: N = (cfg_div < 2) ? 2 : cfg_div.
- Effective skew: S = min(cfg_skew, MAX_SKEW).
- Waveform:
  - cnt runs 0..N-1 and wraps.
  - clk_ideal = 1 while cnt < N/2 (floor), else 0.
  - Odd N gives a shorter high phase; N=5 → high 2, low 3.
- Per-channel FSM has three states.
- IDLE (cfg_rdy = 1):
  - cnt = 0, clk_ideal = 0.
  - Handshake at cycle T with en = 1: latch N and S, go to RUN.
  - clk_ideal = 1 and tick = 1 at T+1.
  - Handshake with en = 0: latch N and S, stay in IDLE.
- RUN (cfg_rdy = 1):
  - Handshake: capture config into the pending register, go to PEND.
  - cfg_rdy = 0 from the next cycle.
- PEND (cfg_rdy = 0):
  - Counting continues with the old N and S.
  - On the cycle with cnt == N-1, the new N/S/en become active.
  - If en = 1: go to RUN, cnt → 0 next cycle (clk_ideal high, tick).
  - If en = 0: go to IDLE, clk_ideal stays low.
- cfg_vld while cfg_rdy = 0 is not accepted; the requester holds.
- Handshake: transfer only when cfg_vld & cfg_rdy.
- clk_out:
  - Tap S of a MAX_SKEW+1 deep shift line fed by clk_ideal; tap 0 = clk_ideal.
  - A skew change is applied at the same boundary as the ratio change.
  - On a skew change the line is not flushed; tap select switches at the boundary.
  - Switching to IDLE: clk_out drains the delay line, then stays 0.
- tick = (state ∈ {RUN, PEND}) & (next cnt == 0) & (clk_ideal rising). It is registered, aligned with clk_ideal.
- Channels are fully independent; simultaneous handshakes on several channels are all accepted.
- rst mid-operation: all channels return to their reset values on the next edge; a pending config is discarded.
- rst has priority over any handshake in the same cycle.

Optional Feature:
- Macro: CN_CLK_GEN_GATE_EN.
- Defined:
  - Adds input gate_en[NUM_CH].
  - clk_out = delayed clock & gate_q.
  - gate_q samples gate_en only in cycles where the delayed clock is 0 (glitch-free gating).
  - clk_ideal and tick are ungated.
- Undefined:
  - No gate_en port.
  - clk_out is the ungated delayed clock.

Decomposition:
- Package cn_clk_gen_pkg holds:
  - state enum ch_state_e {IDLE, RUN, PEND};
  - struct ch_cfg_t {div, skew, en};
  - function eff_div() implementing the N clamp.
- Sub-module cn_clk_gen_ch contains one channel: FSM, counter, pending register, skew line and gate. The top generate-instantiates NUM_CH of them and slices the buses.

Test Plan:
- Reset then cfg ch0 div=4 skew=0 en=1 at T → clk_ideal 1,1,0,0 repeating from T+1; clk_out identical; tick at T+1, T+5, T+9.
- ch1 div=5 skew=3 en=1 → clk_ideal high 2 / low 3; clk_out same waveform shifted by exactly 3 cycles; div=0 and div=1 each yield a period of 2.
- ch0 running div=4, reconfigure mid-period to div=6 → cfg_rdy low until the boundary; old period completes intact; the next period is 6 cycles with no runt pulse.
- ch2 running, cfg en=0 → clk_ideal stops low at the boundary; clk_out drains after S cycles; cfg_rdy returns to 1; a later en=1 restarts with a tick one cycle after the handshake.
- Simultaneous handshakes on all 4 channels, with rst asserted at cnt=2 of ch3 → all outputs 0 and cfg_rdy all 1 on the next edge; the pending config is discarded.
- With CN_CLK_GEN_GATE_EN: toggle gate_en mid-high-phase → clk_out changes only after the delayed clock falls; no high pulse shorter than the full high phase.
